// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between instruction fetch and the data stage; one outstanding
// transaction, round-robin on contention, flush cancellation and a response watchdog.
module mem_port_arbiter #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        bus_err
);
  localparam int CW = $clog2(MAX_WAIT) + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;       // 0 = fetch, 1 = data
  logic            last_gnt_q, last_gnt_d;
  logic            drop_q, drop_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_wr_q, mem_wr_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [31:0]     i_rdata_q, i_rdata_d;
  logic [31:0]     d_rdata_q, d_rdata_d;
  logic            i_done_q, i_done_d;
  logic            d_done_q, d_done_d;
  logic            bus_err_q, bus_err_d;

  logic            i_elig, d_elig, gnt_vld, gnt_owner, timeout;
  logic [CW-1:0]   cnt_inc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_gnt_q  <= 1'b0;
      drop_q      <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wstrb_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_gnt_q  <= last_gnt_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // A requester whose done is high this cycle is still holding its old request.
  always_comb begin
    i_elig    = i_req & ~i_done_q;
    d_elig    = d_req & ~d_done_q;
    cnt_inc   = cnt_q + CW'(1);
    timeout   = (cnt_inc == CW'(MAX_WAIT));
    gnt_vld   = 1'b0;
    gnt_owner = 1'b0;
    state_d   = state_q;
    case (state_q)
      IDLE: begin
        if (!flush && (i_elig || d_elig)) begin
          gnt_vld   = 1'b1;
          gnt_owner = (i_elig && d_elig) ? ~last_gnt_q : d_elig;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (timeout)          state_d = IDLE;
        else if (mem_addr_ok) state_d = DATA;
        else if (flush)       state_d = IDLE;
      end
      DATA: begin
        if (mem_data_ok)  state_d = IDLE;
        else if (timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    last_gnt_d  = last_gnt_q;
    drop_d      = drop_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    bus_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          owner_d    = gnt_owner;
          last_gnt_d = gnt_owner;
          drop_d     = 1'b0;
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          if (gnt_owner) begin
            mem_wr_d    = d_wr;
            mem_wstrb_d = d_wr ? d_wstrb : 4'b0000;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            mem_wr_d    = 1'b0;
            mem_wstrb_d = 4'b0000;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
          end
        end
      end
      ADDR: begin
        cnt_d = cnt_inc;
        if (timeout) begin
          bus_err_d = 1'b1;
          mem_req_d = 1'b0;
        end else if (mem_addr_ok) begin
          mem_req_d = 1'b0;
          if (flush) drop_d = 1'b1;
        end else if (flush) begin
          mem_req_d = 1'b0;
        end
      end
      DATA: begin
        cnt_d = cnt_inc;
        if (mem_data_ok) begin
          // A flush seen now or earlier swallows the response.
          if (!(drop_q || flush)) begin
            if (owner_q) begin
              d_done_d = 1'b1;
              if (!mem_wr_q) d_rdata_d = mem_rdata;
            end else begin
              i_done_d  = 1'b1;
              i_rdata_d = mem_rdata;
            end
          end
        end else begin
          if (flush) drop_d = 1'b1;
          if (timeout) bus_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign bus_err   = bus_err_q;
  assign stall     = (i_req & ~i_done_q) | (d_req & ~d_done_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: issued memory transactions and completions are
// checked against queues filled as each request is driven.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        resetn, flush;
  logic        i_req, d_req, d_wr;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_done, d_done, mem_req, mem_wr, stall, bus_err;
  logic [3:0]  mem_wstrb;

  mem_port_arbiter #(.MAX_WAIT(16)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .stall(stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic wr; logic [3:0] strb; logic [31:0] addr; logic [31:0] wdata;} mem_t;
  typedef struct packed {logic is_d; logic [31:0] rdata;} done_t;

  mem_t  mem_q[$];
  done_t done_q[$];
  mem_t  mon_got, mon_exp;
  done_t dn_exp;
  int    total = 0, bad = 0;
  logic [31:0] exp_i_rdata = '0, exp_d_rdata = '0;

  // Address handshakes and done pulses are popped against the queues.
  always @(negedge clk) begin
    if (resetn) begin
      if (mem_req && mem_addr_ok) begin
        mon_got = {mem_wr, mem_wstrb, mem_addr, mem_wdata};
        total++;
        if (mem_q.size() == 0) begin
          bad++; $display("FAIL mem_issue unexpected addr=%h", mem_addr);
        end else begin
          mon_exp = mem_q.pop_front();
          if (mon_got.wr !== mon_exp.wr || mon_got.strb !== mon_exp.strb ||
              mon_got.addr !== mon_exp.addr || (mon_exp.wr && mon_got.wdata !== mon_exp.wdata)) begin
            bad++;
            $display("FAIL mem_issue got wr=%b strb=%b addr=%h wdata=%h want wr=%b strb=%b addr=%h wdata=%h",
                     mon_got.wr, mon_got.strb, mon_got.addr, mon_got.wdata,
                     mon_exp.wr, mon_exp.strb, mon_exp.addr, mon_exp.wdata);
          end
        end
      end
      if (i_done) begin
        total++;
        if (done_q.size() == 0 || done_q[0].is_d) begin
          bad++; $display("FAIL i_done unexpected pulse rdata=%h", i_rdata);
        end else begin
          dn_exp = done_q.pop_front();
          if (i_rdata !== dn_exp.rdata) begin
            bad++; $display("FAIL i_done_rdata got=%h want=%h", i_rdata, dn_exp.rdata);
          end
        end
      end
      if (d_done) begin
        total++;
        if (done_q.size() == 0 || !done_q[0].is_d) begin
          bad++; $display("FAIL d_done unexpected pulse rdata=%h", d_rdata);
        end else begin
          dn_exp = done_q.pop_front();
          if (d_rdata !== dn_exp.rdata) begin
            bad++; $display("FAIL d_done_rdata got=%h want=%h", d_rdata, dn_exp.rdata);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Memory responder: address accepted after alat extra cycles, data dlat cycles later.
  // Returns in the cycle where the owner's done should be visible.
  task automatic serve(input int alat, input int dlat, input logic [31:0] rd);
    int n = 0;
    while (mem_req !== 1'b1 && n < 32) begin cyc(); n++; end
    total++;
    if (mem_req !== 1'b1) begin
      bad++; $display("FAIL serve_wait mem_req=%b want 1", mem_req);
      return;
    end
    repeat (alat) cyc();
    mem_addr_ok = 1'b1; cyc(); mem_addr_ok = 1'b0;
    repeat (dlat) cyc();
    mem_data_ok = 1'b1; mem_rdata = rd; cyc(); mem_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({mem_req, mem_wr, i_done, d_done, bus_err, mem_wstrb, mem_addr, mem_wdata, i_rdata, d_rdata} !== '0) begin
      bad++; $display("FAIL reset_outputs req=%b wr=%b idone=%b ddone=%b berr=%b addr=%h want all 0",
                      mem_req, mem_wr, i_done, d_done, bus_err, mem_addr);
    end
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_fetch_only();
    i_req = 1'b1; i_addr = 32'hBFC0_0000;
    mem_q.push_back('{1'b0, 4'h0, 32'hBFC0_0000, 32'h0});
    done_q.push_back('{1'b0, 32'h3C08_1234});
    exp_i_rdata = 32'h3C08_1234;
    cyc();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL fetch_req_c1 got=%b want=1", mem_req); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL fetch_stall got=%b want=1", stall); end
    cyc();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL fetch_req_c2 got=%b want=1", mem_req); end
    mem_addr_ok = 1'b1;
    cyc();
    mem_addr_ok = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL fetch_req_c3 got=%b want=0", mem_req); end
    cyc();
    mem_data_ok = 1'b1; mem_rdata = 32'h3C08_1234;
    total++; if (i_done !== 1'b0) begin bad++; $display("FAIL fetch_early_done got=%b want=0", i_done); end
    cyc();
    mem_data_ok = 1'b0;
    total++; if (i_done !== 1'b1) begin bad++; $display("FAIL fetch_done_c5 got=%b want=1", i_done); end
    total++; if (i_rdata !== exp_i_rdata) begin bad++; $display("FAIL fetch_rdata got=%h want=%h", i_rdata, exp_i_rdata); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL fetch_stall_done got=%b want=0", stall); end
    cyc();
    i_req = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL fetch_no_reissue mem_req=%b want=0", mem_req); end
    total++; if (i_rdata !== exp_i_rdata) begin bad++; $display("FAIL fetch_rdata_hold got=%h want=%h", i_rdata, exp_i_rdata); end
    cyc();
  endtask

  task automatic test_round_robin();
    i_req = 1'b1; i_addr = 32'h0040_0000;
    d_req = 1'b1; d_wr = 1'b0; d_wstrb = 4'b1111; d_addr = 32'h8000_1000; d_wdata = 32'h1234_5678;
    mem_q.push_back('{1'b0, 4'h0, 32'h8000_1000, 32'h0});
    mem_q.push_back('{1'b0, 4'h0, 32'h0040_0000, 32'h0});
    done_q.push_back('{1'b1, 32'h1111_2222});
    done_q.push_back('{1'b0, 32'h3333_4444});
    cyc();
    total++; if (mem_addr !== 32'h8000_1000) begin bad++; $display("FAIL rr_first_d got=%h want=80001000", mem_addr); end
    mem_addr_ok = 1'b1; cyc(); mem_addr_ok = 1'b0;
    cyc();
    mem_data_ok = 1'b1; mem_rdata = 32'h1111_2222; cyc(); mem_data_ok = 1'b0;
    exp_d_rdata = 32'h1111_2222;
    total++; if (d_done !== 1'b1) begin bad++; $display("FAIL rr_d_done got=%b want=1", d_done); end
    cyc();
    d_req = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0040_0000) begin
      bad++; $display("FAIL rr_then_i got req=%b addr=%h want req=1 addr=00400000", mem_req, mem_addr);
    end
    serve(0, 0, 32'h3333_4444);
    exp_i_rdata = 32'h3333_4444;
    total++; if (i_done !== 1'b1) begin bad++; $display("FAIL rr_i_done got=%b want=1", i_done); end
    total++; if (d_rdata !== exp_d_rdata) begin bad++; $display("FAIL rr_d_rdata_hold got=%h want=%h", d_rdata, exp_d_rdata); end
    cyc();
    i_req = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rr_no_dup got=%b want=0", mem_req); end
    cyc();
  endtask

  task automatic test_store();
    logic [3:0]  strbs [2];
    logic [31:0] datas [2];
    logic [31:0] addrs [2];
    strbs[0] = 4'b1100; datas[0] = 32'hABCD_ABCD; addrs[0] = 32'h8000_0010;
    strbs[1] = 4'b0000; datas[1] = 32'h0F0F_0F0F; addrs[1] = 32'h8000_0014;
    for (int k = 0; k < 2; k++) begin
      d_req = 1'b1; d_wr = 1'b1; d_wstrb = strbs[k]; d_wdata = datas[k]; d_addr = addrs[k];
      mem_q.push_back('{1'b1, strbs[k], addrs[k], datas[k]});
      done_q.push_back('{1'b1, exp_d_rdata});
      serve(1, 1, 32'hDEAD_BEEF);
      total++; if (d_done !== 1'b1) begin bad++; $display("FAIL store_done[%0d] got=%b want=1", k, d_done); end
      total++; if (d_rdata !== exp_d_rdata) begin bad++; $display("FAIL store_rdata[%0d] got=%h want=%h", k, d_rdata, exp_d_rdata); end
      cyc();
      d_req = 1'b0; d_wr = 1'b0;
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL store_no_dup[%0d] got=%b want=0", k, mem_req); end
      cyc();
    end
  endtask

  task automatic test_flush();
    // flush in IDLE blocks the grant for that cycle only
    i_req = 1'b1; i_addr = 32'h0040_0100; flush = 1'b1;
    mem_q.push_back('{1'b0, 4'h0, 32'h0040_0100, 32'h0});
    done_q.push_back('{1'b0, 32'h7777_8888});
    cyc();
    flush = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL flush_idle_grant got=%b want=0", mem_req); end
    serve(0, 0, 32'h7777_8888);
    exp_i_rdata = 32'h7777_8888;
    total++; if (i_done !== 1'b1) begin bad++; $display("FAIL flush_idle_done got=%b want=1", i_done); end
    cyc();
    i_req = 1'b0;
    cyc();
    // flush before the address handshake
    i_req = 1'b1; i_addr = 32'h0040_0200;
    cyc();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL flush_addr_req got=%b want=1", mem_req); end
    flush = 1'b1; i_req = 1'b0;
    cyc();
    flush = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL flush_addr_drop got=%b want=0", mem_req); end
    repeat (3) cyc();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL flush_addr_idle got=%b want=0", mem_req); end
    // flush while waiting for data
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h8000_0100;
    mem_q.push_back('{1'b0, 4'h0, 32'h8000_0100, 32'h0});
    cyc();
    mem_addr_ok = 1'b1; cyc(); mem_addr_ok = 1'b0;
    flush = 1'b1; d_req = 1'b0;
    cyc();
    flush = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h5555_5555;
    cyc();
    mem_data_ok = 1'b0;
    total++; if (d_done !== 1'b0) begin bad++; $display("FAIL flush_data_done got=%b want=0", d_done); end
    total++; if (d_rdata !== exp_d_rdata) begin bad++; $display("FAIL flush_data_rdata got=%h want=%h", d_rdata, exp_d_rdata); end
    cyc();
  endtask

  task automatic test_watchdog();
    int first = -1;
    int hits = 0;
    i_req = 1'b1; i_addr = 32'h0040_0300;
    mem_q.push_back('{1'b0, 4'h0, 32'h0040_0300, 32'h0});
    for (int c = 1; c <= 24; c++) begin
      cyc();
      mem_addr_ok = (c == 2);
      if (bus_err === 1'b1) begin
        hits++;
        if (first < 0) first = c;
        i_req = 1'b0;
      end
    end
    mem_addr_ok = 1'b0;
    total++; if (hits != 1) begin bad++; $display("FAIL wd_pulse_count got=%0d want=1", hits); end
    total++; if (first != 16 && first != 17) begin bad++; $display("FAIL wd_pulse_cycle got=%0d want=16..17", first); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL wd_req_low got=%b want=0", mem_req); end
    mem_data_ok = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    cyc();
    mem_data_ok = 1'b0;
    cyc();
    total++; if (i_rdata !== exp_i_rdata) begin bad++; $display("FAIL wd_stray_rdata got=%h want=%h", i_rdata, exp_i_rdata); end
    i_req = 1'b1; i_addr = 32'h0040_0400;
    mem_q.push_back('{1'b0, 4'h0, 32'h0040_0400, 32'h0});
    done_q.push_back('{1'b0, 32'h9999_AAAA});
    serve(0, 2, 32'h9999_AAAA);
    exp_i_rdata = 32'h9999_AAAA;
    total++; if (i_done !== 1'b1) begin bad++; $display("FAIL wd_recover_done got=%b want=1", i_done); end
    cyc();
    i_req = 1'b0;
    cyc();
  endtask

  task automatic test_async_reset();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h8000_2000;
    mem_q.push_back('{1'b0, 4'h0, 32'h8000_2000, 32'h0});
    cyc();
    mem_addr_ok = 1'b1; cyc(); mem_addr_ok = 1'b0;
    cyc();
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({mem_req, mem_wr, i_done, d_done, bus_err, mem_wstrb, mem_addr, mem_wdata, i_rdata, d_rdata} !== '0) begin
      bad++; $display("FAIL async_reset got addr=%h irdata=%h drdata=%h req=%b want all 0",
                      mem_addr, i_rdata, d_rdata, mem_req);
    end
    d_req = 1'b0; exp_i_rdata = '0; exp_d_rdata = '0;
    cyc();
    resetn = 1'b1;
    cyc();
    i_req = 1'b1; i_addr = 32'hBFC0_0004;
    mem_q.push_back('{1'b0, 4'h0, 32'hBFC0_0004, 32'h0});
    done_q.push_back('{1'b0, 32'h2408_0001});
    serve(1, 1, 32'h2408_0001);
    total++; if (i_done !== 1'b1 || i_rdata !== 32'h2408_0001) begin
      bad++; $display("FAIL reset_restart got done=%b rdata=%h want done=1 rdata=24080001", i_done, i_rdata);
    end
    cyc();
    i_req = 1'b0;
    repeat (2) cyc();
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_wr = 1'b0; d_wstrb = '0; d_addr = '0; d_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    test_reset();
    test_fetch_only();
    test_round_robin();
    test_store();
    test_flush();
    test_watchdog();
    test_async_reset();
    total++;
    if (mem_q.size() != 0 || done_q.size() != 0) begin
      bad++; $display("FAIL leftover mem=%0d done=%0d want 0 0", mem_q.size(), done_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
